player_motion: RTL

Player movement engine for the maze game. It synchronises the four direction buttons and moves the 16×16 player sprite once per video frame. Each proposed step is checked against the current room's wall map through a query handshake, and the block changes room when the sprite leaves the screen edge. It feeds the renderer `x_pos`/`y_pos` (screen-counter coordinates) and the room indices used to select the room's wall map.

---
 rtl/meikyuu_pkg.sv | 27 ++
 rtl/player_motion_if.sv | 21 ++
 rtl/btn_sync.sv | 24 ++
 rtl/player_motion.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/meikyuu_pkg.sv
// Shared maze-game constants and types: screen bounds, sprite size, room grid, FSM states.
package meikyuu_pkg;

    typedef logic [9:0] coord_t;
    typedef logic [2:0] room_t;

    localparam coord_t STEP    = 10'd2;
    localparam coord_t SPRITE  = 10'd16;
    localparam coord_t H_MIN   = 10'd97;
    localparam coord_t H_MAX   = 10'd736;
    localparam coord_t V_MIN   = 10'd3;
    localparam coord_t V_MAX   = 10'd482;
    localparam coord_t X_START = 10'd408;
    localparam coord_t Y_START = 10'd234;

    localparam room_t GRID_W  = 3'd3;
    localparam room_t GRID_H  = 3'd3;
    localparam room_t ROOM_X0 = 3'd1;
    localparam room_t ROOM_Y0 = 3'd1;

    typedef enum logic [1:0] {RoomEmpty, RoomMaze, RoomTreasure, RoomExit} room_type_e;

    typedef enum logic [1:0] {StIdle, StCheck, StQuery, StWait} motion_state_e;

    typedef enum logic [1:0] {DirUp, DirDown, DirLeft, DirRight} dir_e;

endpackage

// File: rtl/player_motion_if.sv
// Wall-map query handshake between the motion engine (master) and the map lookup (slave).
interface player_motion_if;
    import meikyuu_pkg::*;

    coord_t cand_x;
    coord_t cand_y;
    logic   query_valid;
    logic   query_done;
    logic   query_blocked;

    modport master (
        output cand_x, cand_y, query_valid,
        input  query_done, query_blocked
    );

    modport slave (
        input  cand_x, cand_y, query_valid,
        output query_done, query_blocked
    );

endinterface

// File: rtl/btn_sync.sv
// Two-flop synchroniser for the four asynchronous direction buttons.
module btn_sync (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_btn,
    output logic [3:0] o_btn
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
        end
    end

    assign o_btn = r_sync;

endmodule

// File: rtl/player_motion.sv
// Per-frame sprite mover: picks a direction, handles room edge exits, and commits
// wall-checked steps through the query handshake.
module player_motion
    import meikyuu_pkg::*;
(
    input  logic   CLOCK_25,
    input  logic   reset,
    input  logic   btn_up,
    input  logic   btn_down,
    input  logic   btn_left,
    input  logic   btn_right,
    input  logic   frame_tick,
    player_motion_if.master qif,
    output coord_t x_pos,
    output coord_t y_pos,
    output room_t  mapa_pos_x,
    output room_t  mapa_pos_y,
    output logic   room_changed,
    output logic   busy
);

    localparam coord_t LEFT_LIM  = H_MIN + STEP;
    localparam coord_t RIGHT_LIM = H_MAX + 10'd1 - SPRITE;
    localparam coord_t UP_LIM    = V_MIN + STEP;
    localparam coord_t DOWN_LIM  = V_MAX + 10'd1 - SPRITE;

    logic [3:0]    w_btn;
    logic          w_any;
    dir_e          w_dir;
    coord_t        w_cand_x, w_cand_y, w_wrap_x, w_wrap_y;
    room_t         w_room_x, w_room_y;
    logic          w_exit, w_has_room;

    motion_state_e r_state;
    dir_e          r_dir;
    coord_t        r_x, r_y, r_cand_x, r_cand_y;
    room_t         r_room_x, r_room_y;
    logic          r_query_valid, r_room_changed, r_busy;

    btn_sync u_btn_sync (
        .i_clk   (CLOCK_25),
        .i_rst_n (reset),
        .i_btn   ({btn_up, btn_down, btn_left, btn_right}),
        .o_btn   (w_btn)
    );

    always_comb begin
        w_any = |w_btn;
        if (w_btn[3])      w_dir = DirUp;
        else if (w_btn[2]) w_dir = DirDown;
        else if (w_btn[1]) w_dir = DirLeft;
        else               w_dir = DirRight;
    end

    // Edge tests compare before stepping so the subtraction never wraps.
    always_comb begin
        w_cand_x   = r_x;
        w_cand_y   = r_y;
        w_wrap_x   = r_x;
        w_wrap_y   = r_y;
        w_room_x   = r_room_x;
        w_room_y   = r_room_y;
        w_exit     = 1'b0;
        w_has_room = 1'b0;
        unique case (r_dir)
            DirUp: begin
                if (r_y < UP_LIM) begin
                    w_exit     = 1'b1;
                    w_has_room = (r_room_y != '0);
                    w_wrap_y   = DOWN_LIM;
                    w_room_y   = r_room_y - 3'd1;
                end else begin
                    w_cand_y = r_y - STEP;
                end
            end
            DirDown: begin
                if (r_y + STEP > DOWN_LIM) begin
                    w_exit     = 1'b1;
                    w_has_room = (r_room_y < GRID_H - 3'd1);
                    w_wrap_y   = V_MIN;
                    w_room_y   = r_room_y + 3'd1;
                end else begin
                    w_cand_y = r_y + STEP;
                end
            end
            DirLeft: begin
                if (r_x < LEFT_LIM) begin
                    w_exit     = 1'b1;
                    w_has_room = (r_room_x != '0);
                    w_wrap_x   = RIGHT_LIM;
                    w_room_x   = r_room_x - 3'd1;
                end else begin
                    w_cand_x = r_x - STEP;
                end
            end
            DirRight: begin
                if (r_x + STEP > RIGHT_LIM) begin
                    w_exit     = 1'b1;
                    w_has_room = (r_room_x < GRID_W - 3'd1);
                    w_wrap_x   = H_MIN;
                    w_room_x   = r_room_x + 3'd1;
                end else begin
                    w_cand_x = r_x + STEP;
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK_25) begin
        if (!reset) begin
            r_state        <= StIdle;
            r_dir          <= DirUp;
            r_x            <= X_START;
            r_y            <= Y_START;
            r_cand_x       <= X_START;
            r_cand_y       <= Y_START;
            r_room_x       <= ROOM_X0;
            r_room_y       <= ROOM_Y0;
            r_query_valid  <= 1'b0;
            r_room_changed <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_query_valid  <= 1'b0;
            r_room_changed <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (frame_tick && w_any) begin
                        r_dir   <= w_dir;
                        r_state <= StCheck;
                        r_busy  <= 1'b1;
                    end
                end
                StCheck: begin
                    if (w_exit) begin
                        if (w_has_room) begin
                            r_x            <= w_wrap_x;
                            r_y            <= w_wrap_y;
                            r_room_x       <= w_room_x;
                            r_room_y       <= w_room_y;
                            r_room_changed <= 1'b1;
                        end
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cand_x      <= w_cand_x;
                        r_cand_y      <= w_cand_y;
                        r_query_valid <= 1'b1;
                        r_state       <= StQuery;
                    end
                end
                StQuery: r_state <= StWait;
                StWait: begin
                    if (qif.query_done) begin
                        if (!qif.query_blocked) begin
                            r_x <= r_cand_x;
                            r_y <= r_cand_y;
                        end
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign qif.cand_x      = r_cand_x;
    assign qif.cand_y      = r_cand_y;
    assign qif.query_valid = r_query_valid;
    assign x_pos           = r_x;
    assign y_pos           = r_y;
    assign mapa_pos_x      = r_room_x;
    assign mapa_pos_y      = r_room_y;
    assign room_changed    = r_room_changed;
    assign busy            = r_busy;

endmodule
